tx_bit1_phy: RTL

SPI slave transmit PHY. It serialises parallel words from the core onto miso in step with the external master's sck/cs_n. All SPI pins are oversampled in the local clock domain. It is the MISO-side counterpart of the slave receive path and shares that path's PHASE/ACTIVE mode convention, so a receive/transmit pair can be instantiated per chip-select.

---
 rtl/spi_phy_pkg.sv | 28 ++
 rtl/cross_clk_sync.sv | 21 ++
 rtl/edge_generator.sv | 39 +++
 rtl/tx_bit1_phy.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/spi_phy_pkg.sv
// Shared SPI slave PHY definitions: FSM state encoding and the
// CPOL/CPHA mode decode used by both the receive and transmit PHYs.
package spi_phy_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_END
    } spi_state_t;

    typedef struct packed {
        logic sample_rise;
        logic launch_rise;
    } edge_sel_t;

    // Modes 0 and 3 sample on sck rising; modes 1 and 2 on sck falling.
    function automatic edge_sel_t mode_decode(
        input logic active,
        input logic phase
    );
        edge_sel_t sel;
        sel.sample_rise = (active == phase);
        sel.launch_rise = (active != phase);
        return sel;
    endfunction

endpackage

// File: rtl/cross_clk_sync.sv
// Two-flop synchroniser for a single asynchronous level.
// Ports: clock, rst_n, i_async (raw pin), o_sync (clock-domain level).
module cross_clk_sync #(
    parameter bit RST_VAL = 1'b0
) (
    input  logic clock,
    input  logic rst_n,
    input  logic i_async,
    output logic o_sync
);

    logic [1:0] r_ff;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) r_ff <= {2{RST_VAL}};
        else        r_ff <= {r_ff[0], i_async};
    end

    assign o_sync = r_ff[1];

endmodule

// File: rtl/edge_generator.sv
// Rise/fall pulse generator on a synchronised level.
// Ports: clock, rst_n, i_sig, o_rise, o_fall. FAST=1 gives the
// pulses combinationally, FAST=0 gives them one cycle later from flops.
module edge_generator #(
    parameter bit FAST    = 1'b0,
    parameter bit RST_VAL = 1'b0
) (
    input  logic clock,
    input  logic rst_n,
    input  logic i_sig,
    output logic o_rise,
    output logic o_fall
);

    logic r_prev;
    logic r_rise;
    logic r_fall;
    logic w_rise;
    logic w_fall;

    assign w_rise = i_sig & ~r_prev;
    assign w_fall = ~i_sig & r_prev;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_prev <= RST_VAL;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_prev <= i_sig;
            r_rise <= w_rise;
            r_fall <= w_fall;
        end
    end

    assign o_rise = FAST ? w_rise : r_rise;
    assign o_fall = FAST ? w_fall : r_fall;

endmodule

// File: rtl/tx_bit1_phy.sv
// SPI slave transmit PHY: serialises core words onto miso, MSB first.
// Ports: clock/rst_n, SPI pins sck/cs_n/miso/miso_oe, core handshake
// tx_data/tx_valid/tx_ready, status pulses start/finish/word_done/underrun.
module tx_bit1_phy
    import spi_phy_pkg::*;
#(
    parameter bit              PHASE  = 1'b0,
    parameter bit              ACTIVE = 1'b0,
    parameter int              DSIZE  = 8,
    parameter logic [DSIZE-1:0] FILL  = {DSIZE{1'b1}}
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             sck,
    input  logic             cs_n,
    output logic             miso,
    output logic             miso_oe,
    input  logic [DSIZE-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             start,
    output logic             finish,
    output logic             word_done,
    output logic             underrun
);

    localparam int             CW   = (DSIZE > 2) ? $clog2(DSIZE) : 1;
    localparam logic [CW-1:0]  LAST = CW'(DSIZE - 1);
    localparam edge_sel_t      SEL  = mode_decode(ACTIVE, PHASE);

    logic w_sck_s, w_csn_s;
    logic w_sck_rise, w_sck_fall;
    logic w_cs_rise, w_cs_fall;
    logic w_sample, w_launch;

    spi_state_t       r_state, w_state_nxt;
    logic [DSIZE-1:0] r_shift, w_shift_nxt;
    logic [CW-1:0]    r_bit_cnt, w_cnt_nxt;
    logic             r_miso, w_miso_nxt;
    logic             r_reload, w_reload_nxt;
    logic [DSIZE-1:0] r_hold;
    logic             r_hold_full;
    logic             r_oe;
    logic             w_load;
    logic             w_accept;
    logic [DSIZE-1:0] w_src;

    cross_clk_sync #(.RST_VAL(ACTIVE)) u_sck_sync (
        .clock   (clock),
        .rst_n   (rst_n),
        .i_async (sck),
        .o_sync  (w_sck_s)
    );

    cross_clk_sync #(.RST_VAL(1'b1)) u_cs_sync (
        .clock   (clock),
        .rst_n   (rst_n),
        .i_async (cs_n),
        .o_sync  (w_csn_s)
    );

    edge_generator #(.FAST(1'b1), .RST_VAL(ACTIVE)) u_sck_edge (
        .clock  (clock),
        .rst_n  (rst_n),
        .i_sig  (w_sck_s),
        .o_rise (w_sck_rise),
        .o_fall (w_sck_fall)
    );

    // cs_n fall = select, cs_n rise = deselect.
    edge_generator #(.FAST(1'b0), .RST_VAL(1'b1)) u_cs_edge (
        .clock  (clock),
        .rst_n  (rst_n),
        .i_sig  (w_csn_s),
        .o_rise (w_cs_rise),
        .o_fall (w_cs_fall)
    );

    assign w_sample = SEL.sample_rise ? w_sck_rise : w_sck_fall;
    assign w_launch = SEL.launch_rise ? w_sck_rise : w_sck_fall;
    assign w_src    = r_hold_full ? r_hold : FILL;
    assign w_accept = tx_valid & ~r_hold_full;

    always_comb begin
        w_state_nxt  = r_state;
        w_shift_nxt  = r_shift;
        w_cnt_nxt    = r_bit_cnt;
        w_miso_nxt   = r_miso;
        w_reload_nxt = r_reload;
        w_load       = 1'b0;
        start        = 1'b0;
        finish       = 1'b0;
        word_done    = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_cs_fall) begin
                    start       = 1'b1;
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_load       = 1'b1;
                w_shift_nxt  = w_src;
                w_cnt_nxt    = '0;
                w_reload_nxt = 1'b0;
                if (!PHASE) w_miso_nxt = w_src[DSIZE-1];
                w_state_nxt = w_cs_rise ? ST_END : ST_SHIFT;
            end
            ST_SHIFT: begin
                // Deselect takes priority over any sck edge this cycle.
                if (w_cs_rise) begin
                    w_state_nxt = ST_END;
                end else begin
                    if (w_sample) begin
                        if (r_bit_cnt == LAST) begin
                            word_done    = 1'b1;
                            w_cnt_nxt    = '0;
                            w_reload_nxt = 1'b1;
                        end else begin
                            w_cnt_nxt = r_bit_cnt + 1'b1;
                        end
                    end
                    if (w_launch) begin
                        if (r_reload) begin
                            // PHASE=1 drives the MSB now, so the
                            // register keeps only the remaining bits.
                            w_load       = 1'b1;
                            w_reload_nxt = 1'b0;
                            w_miso_nxt   = w_src[DSIZE-1];
                            w_shift_nxt  = PHASE ? (w_src << 1) : w_src;
                        end else if (!PHASE) begin
                            w_miso_nxt  = r_shift[DSIZE-2];
                            w_shift_nxt = r_shift << 1;
                        end else begin
                            w_miso_nxt  = r_shift[DSIZE-1];
                            w_shift_nxt = r_shift << 1;
                        end
                    end
                end
            end
            ST_END: begin
                finish       = 1'b1;
                w_cnt_nxt    = '0;
                w_miso_nxt   = 1'b0;
                w_reload_nxt = 1'b0;
                w_state_nxt  = ST_IDLE;
            end
        endcase
    end

    assign underrun = w_load & ~r_hold_full;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_shift     <= FILL;
            r_bit_cnt   <= '0;
            r_miso      <= 1'b0;
            r_reload    <= 1'b0;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_oe        <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_shift     <= w_shift_nxt;
            r_bit_cnt   <= w_cnt_nxt;
            r_miso      <= w_miso_nxt;
            r_reload    <= w_reload_nxt;
            r_oe        <= ~w_csn_s;
            // A word accepted while an underrun load happens stays held.
            r_hold_full <= (r_hold_full & ~w_load) | w_accept;
            if (w_accept) r_hold <= tx_data;
        end
    end

    assign miso     = r_miso;
    assign miso_oe  = r_oe;
    assign tx_ready = ~r_hold_full;

endmodule
